bit_unstuff_deser: RTL and testbench
====================================

Name: bit_unstuff_deser

Overview:
- Receive-side stage directly downstream of the NRZI decoder.
- Consumes the decoded serial bit stream and strips USB stuffed bits (a 0 following STUFF_LEN consecutive 1s).
- Detects stuffing violations and assembles the remaining data bits, LSB-first, into bytes for the packet-level receiver.
- Sync pattern is already removed upstream; the first valid bit after IDLE is bit 0 of the PID byte.

Parameters:
- STUFF_LEN, 6: number of consecutive 1s after which a stuffed 0 is expected.
- DATA_W, 8: output word width in bits.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- inb  in  1  decoded bit from the NRZI decoder.
- in_valid  in  1  inb is a real bit this cycle (bit-rate strobe / recving).
- eop_in  in  1  end-of-packet marker from the line receiver, 1-cycle pulse.
- byte_out  out  DATA_W  assembled word, LSB = first received bit.
- byte_valid  out  1  1-cycle strobe; byte_out is valid.
- pkt_done  out  1  1-cycle strobe when a packet ends normally or abnormally.
- stuff_err  out  1  1-cycle strobe; a stuffing violation was seen.
- trunc_err  out  1  1-cycle strobe; EOP arrived with a partial word.
- crc_ok  out  1  CRC16 residual check result, valid with pkt_done.

Behaviour:
- Reset (async, rst=1):
  - State = IDLE; ones_cnt = 0; bit_cnt = 0; shift register = 0.
  - byte_out = 0; all strobes = 0; crc_ok = 0.
  - Reset asserted mid-packet discards everything, with no strobes.
- States: IDLE, RECV, ERROR.
- IDLE:
  - First in_valid=1 moves to RECV and processes that bit as a data bit.
  - eop_in in IDLE is ignored.
- RECV, on an in_valid cycle:
  - ones_cnt==STUFF_LEN and inb==0: stuffed bit. Drop it; ones_cnt := 0; bit_cnt unchanged.
  - ones_cnt==STUFF_LEN and inb==1: violation. stuff_err pulses next cycle; go to ERROR.
  - Otherwise: data bit. Shift it into the MSB of the shift register (right shift); bit_cnt++; ones_cnt := inb ? ones_cnt+1 : 0.
  - When the data bit makes bit_cnt==DATA_W: next cycle byte_out = completed word and byte_valid=1; bit_cnt := 0.
  - Latency: the last data bit is sampled at edge N; byte_valid is high for the cycle after edge N+1.
  - ones_cnt does not reset at byte boundaries; stuffing spans bytes.
- RECV, on an eop_in cycle (EOP has priority over a simultaneous in_valid, whose bit is ignored):
  - pkt_done pulses next cycle.
  - trunc_err pulses with pkt_done if bit_cnt != 0; the partial word is discarded.
  - Go to IDLE; clear the counters.
- ERROR:
  - Ignores bits.
  - On eop_in: pkt_done pulses (no trunc_err); go to IDLE.
- byte_out holds its last value between strobes.
- in_valid low: state is held.
- Counter widths: ones_cnt is clog2(STUFF_LEN+1) bits; bit_cnt is clog2(DATA_W+1) bits; neither may wrap.

Optional Feature:
- Macro: UNSTUFF_CRC16_EN.
- Defined:
  - A 16-bit CRC register (polynomial x^16+x^15+x^2+1, init 0xFFFF) updates on every data bit after the first DATA_W bits of the packet, so the PID is excluded.
  - The register reinitialises on entry to RECV.
  - At pkt_done, crc_ok=1 iff the register equals the residual 0x800D and trunc_err=0. crc_ok holds until the next pkt_done or reset.
- Not defined: crc_ok is tied to 0 and no CRC logic is built.

Test Plan:
- Reset: hold rst=1 for 3 cycles, then release → all outputs 0, state IDLE.
- Stuff removal: send byte 0xFF LSB-first with a stuffed 0 after the 6th 1, then EOP → single byte_valid with byte_out=0xFF, pkt_done=1, stuff_err=0, trunc_err=0.
- Plain data: send bytes 0xA5 then 0x3C, then EOP → byte_valid twice, values 0xA5 then 0x3C; pkt_done once.
- Violation: send seven consecutive 1 bits → stuff_err pulses once; further bits produce no byte_valid; the following EOP gives pkt_done=1, trunc_err=0.
- Truncation and priority: send 3 bits with eop_in coincident with the 4th in_valid → no byte_valid; pkt_done=1, trunc_err=1. Separately, assert rst mid-byte → no strobes, and the next packet decodes correctly.
- CRC (with UNSTUFF_CRC16_EN): PID 0xC3, data 0x00 0x00, EOP → crc_ok=1. PID 0xC3, data 0x00 0x01, EOP → crc_ok=0.

Source files
------------

// File: rtl/bit_unstuff_deser.sv
// Removes USB stuffed bits from the decoded serial stream and packs data bits LSB-first into words.
// Latency: byte_valid is high in the second cycle after the last data bit is sampled; every other strobe arrives one cycle after its cause.
// Backpressure: none. One bit per in_valid strobe, and the packet receiver must take every strobe.
//
// Ports:
//   clk, rst          : clock and asynchronous active-high reset
//   inb, in_valid     : decoded bit and its bit-rate qualifier from the NRZI decoder
//   eop_in            : one-cycle end-of-packet marker from the line receiver
//   byte_out/valid    : assembled word and its one-cycle strobe
//   pkt_done          : packet ended (normally or after an error)
//   stuff_err         : a 1 arrived where a stuffed 0 was due
//   trunc_err         : EOP arrived with a partial word pending (reported with pkt_done)
//   crc_ok            : CRC16 residual matched at pkt_done (only with UNSTUFF_CRC16_EN)
// Optional feature macro: UNSTUFF_CRC16_EN builds the CRC16 residual checker.
module bit_unstuff_deser #(
  parameter int STUFF_LEN = 6,
  parameter int DATA_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inb,
  input  logic              in_valid,
  input  logic              eop_in,
  output logic [DATA_W-1:0] byte_out,
  output logic              byte_valid,
  output logic              pkt_done,
  output logic              stuff_err,
  output logic              trunc_err,
  output logic              crc_ok
);

  localparam int OW = $clog2(STUFF_LEN + 1);
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [OW-1:0] ONES_MAX  = OW'(STUFF_LEN);
  localparam logic [BW-1:0] BYTE_FULL = BW'(DATA_W);

  typedef enum logic [1:0] {IDLE, RECV, ERROR} state_t;

  state_t            state_q, state_d;
  logic [OW-1:0]     ones_q;
  logic [BW-1:0]     bit_q;
  logic [DATA_W-1:0] sh_q;

  logic take_bit, drop_bit, done_d, serr_d, trunc_d, full, clr;

  // A completed word waits one cycle in the shift register, then drains here.
  assign full = (bit_q == BYTE_FULL);
  assign clr  = (state_d != RECV);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = RECV;
      RECV: begin
        if (eop_in)                                      state_d = IDLE;
        else if (in_valid && (ones_q == ONES_MAX) && inb) state_d = ERROR;
      end
      ERROR:   if (eop_in) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    take_bit = 1'b0;
    drop_bit = 1'b0;
    done_d   = 1'b0;
    serr_d   = 1'b0;
    trunc_d  = 1'b0;
    case (state_q)
      // The first bit after IDLE is always data because ones_q is zero here.
      IDLE: take_bit = in_valid;
      RECV: begin
        if (eop_in) begin
          done_d = 1'b1;
          // A full word still draining is not a truncation.
          trunc_d = (bit_q != '0) && !full;
        end else if (in_valid) begin
          if (ones_q == ONES_MAX) begin
            if (inb) serr_d   = 1'b1;
            else     drop_bit = 1'b1;
          end else begin
            take_bit = 1'b1;
          end
        end
      end
      ERROR: done_d = eop_in;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ones_q     <= '0;
      bit_q      <= '0;
      sh_q       <= '0;
      byte_out   <= '0;
      byte_valid <= 1'b0;
      pkt_done   <= 1'b0;
      stuff_err  <= 1'b0;
      trunc_err  <= 1'b0;
    end else begin
      byte_valid <= full;
      pkt_done   <= done_d;
      stuff_err  <= serr_d;
      trunc_err  <= trunc_d;
      if (full) byte_out <= sh_q;
      if (take_bit) begin
        sh_q   <= {inb, sh_q[DATA_W-1:1]};
        ones_q <= inb ? ones_q + OW'(1) : '0;
        bit_q  <= full ? BW'(1) : bit_q + BW'(1);
      end else begin
        if (drop_bit) ones_q <= '0;
        if (full)     bit_q  <= '0;
      end
      if (clr) begin
        ones_q <= '0;
        bit_q  <= '0;
      end
    end
  end

`ifdef UNSTUFF_CRC16_EN
  logic [15:0] crc_q;
  logic        pid_seen_q;
  logic        crc_fb;

  assign crc_fb = crc_q[15] ^ inb;

  // The first word (the PID) is excluded. The bit that arrives while the PID drains is the first one covered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_q      <= 16'hFFFF;
      pid_seen_q <= 1'b0;
      crc_ok     <= 1'b0;
    end else begin
      if (state_q == IDLE && in_valid) begin
        crc_q      <= 16'hFFFF;
        pid_seen_q <= 1'b0;
      end else begin
        if (take_bit && (pid_seen_q || full))
          crc_q <= {crc_q[14:0], 1'b0} ^ (crc_fb ? 16'h8005 : 16'h0000);
        if (full) pid_seen_q <= 1'b1;
      end
      if (done_d) crc_ok <= (crc_q == 16'h800D) && !trunc_d;
    end
  end
`else
  assign crc_ok = 1'b0;
`endif

endmodule

// File: tb/tb_bit_unstuff_deser.sv
// Bench for bit_unstuff_deser. Packets are described as lists of data bits.
// A reference encoder inserts the stuffed bits, and the expected words, flags and CRC come from those lists.
module tb_bit_unstuff_deser;
  logic       clk = 1'b0;
  logic       rst, inb, in_valid, eop_in;
  logic [7:0] byte_out;
  logic       byte_valid, pkt_done, stuff_err, trunc_err, crc_ok;

  always #5 clk = ~clk;

  bit_unstuff_deser #(.STUFF_LEN(6), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .inb(inb), .in_valid(in_valid), .eop_in(eop_in),
    .byte_out(byte_out), .byte_valid(byte_valid), .pkt_done(pkt_done),
    .stuff_err(stuff_err), .trunc_err(trunc_err), .crc_ok(crc_ok)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] got_bytes[$];
  int   n_done = 0, n_trunc = 0, n_serr = 0;
  logic last_crc = 1'b0;

  always @(negedge clk) begin
    if (byte_valid) got_bytes.push_back(byte_out);
    if (pkt_done) begin
      n_done++;
      last_crc = crc_ok;
    end
    if (trunc_err) n_trunc++;
    if (stuff_err) n_serr++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic cyc(input logic iv, input logic b, input logic e);
    in_valid = iv;
    inb      = b;
    eop_in   = e;
    @(posedge clk);
    #1;
  endtask

  bit dbits[$];
  bit line[$];

  task automatic push_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) dbits.push_back(v[i]);
  endtask

  // Encodes dbits for the line, sends the packet, then checks everything the packet should have produced.
  task automatic run_packet(input bit viol, input int gap_max, input bit eop_bit, input string tag);
    int ones, base_b, base_d, base_t, base_s, nbytes;
    logic [15:0] crc;
    logic [7:0]  eb;
    bit trunc_exp, exp_crc, fb;
    line = {};
    ones = 0;
    foreach (dbits[i]) begin
      line.push_back(dbits[i]);
      ones = dbits[i] ? ones + 1 : 0;
      if (ones == 6) begin
        line.push_back(1'b0);
        ones = 0;
      end
    end
    if (viol) begin
      while (ones < 6) begin
        dbits.push_back(1'b1);
        line.push_back(1'b1);
        ones++;
      end
      line.push_back(1'b1);
      repeat ($urandom_range(0, 4)) line.push_back(1'($urandom));
    end
    base_b = got_bytes.size();
    base_d = n_done;
    base_t = n_trunc;
    base_s = n_serr;
    foreach (line[i]) begin
      repeat ($urandom_range(0, gap_max)) cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b1, line[i], 1'b0);
    end
    repeat ($urandom_range(0, gap_max)) cyc(1'b0, 1'b0, 1'b0);
    cyc(eop_bit, 1'($urandom), 1'b1);
    repeat (4) cyc(1'b0, 1'b0, 1'b0);

    nbytes = dbits.size() / 8;
    check({tag, "_nbytes"}, got_bytes.size() - base_b, nbytes);
    for (int k = 0; k < nbytes; k++) begin
      for (int i = 0; i < 8; i++) eb[i] = dbits[8*k + i];
      if (base_b + k < got_bytes.size())
        check({tag, "_byte"}, got_bytes[base_b + k], eb);
    end
    trunc_exp = !viol && (dbits.size() % 8 != 0);
    check({tag, "_pkt_done"}, n_done - base_d, 1);
    check({tag, "_trunc"}, n_trunc - base_t, trunc_exp);
    check({tag, "_stuff_err"}, n_serr - base_s, viol);
    crc = 16'hFFFF;
    for (int i = 8; i < dbits.size(); i++) begin
      fb  = crc[15] ^ dbits[i];
      crc = {crc[14:0], 1'b0};
      if (fb) crc = crc ^ 16'h8005;
    end
`ifdef UNSTUFF_CRC16_EN
    exp_crc = !trunc_exp && (crc == 16'h800D);
`else
    exp_crc = 1'b0;
`endif
    check({tag, "_crc_ok"}, last_crc, exp_crc);
  endtask

  initial begin
    int b0, d0, s0, t0;
    bit crc_good;
`ifdef UNSTUFF_CRC16_EN
    crc_good = 1'b1;
`else
    crc_good = 1'b0;
`endif
    rst = 1'b1; inb = 1'b0; in_valid = 1'b0; eop_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    check("rst_byte_out", byte_out, 8'h00);
    check("rst_byte_valid", byte_valid, 1'b0);
    check("rst_pkt_done", pkt_done, 1'b0);
    check("rst_stuff_err", stuff_err, 1'b0);
    check("rst_trunc_err", trunc_err, 1'b0);
    check("rst_crc_ok", crc_ok, 1'b0);

    // EOP in IDLE must be ignored.
    d0 = n_done;
    cyc(1'b0, 1'b0, 1'b1);
    repeat (2) cyc(1'b0, 1'b0, 1'b0);
    check("idle_eop_ignored", n_done - d0, 0);

    dbits = {}; push_byte(8'hFF);
    check("ff_line_has_stuff", 32'(dbits.size() + 1), 9);
    run_packet(1'b0, 0, 1'b0, "ff_stuff");

    dbits = {}; push_byte(8'hA5); push_byte(8'h3C);
    run_packet(1'b0, 1, 1'b0, "plain");

    dbits = {};
    run_packet(1'b1, 1, 1'b0, "violation");

    // Three bits, then EOP arrives together with a fourth bit that must be ignored.
    dbits = {1'b1, 1'b0, 1'b1};
    run_packet(1'b0, 0, 1'b1, "trunc_prio");

    // Reset asserted in the middle of a word discards it and raises no strobe.
    b0 = got_bytes.size(); d0 = n_done; s0 = n_serr; t0 = n_trunc;
    cyc(1'b1, 1'b1, 1'b0); cyc(1'b1, 1'b0, 1'b0); cyc(1'b1, 1'b1, 1'b0); cyc(1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    check("midrst_byte_valid", byte_valid, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    check("midrst_no_bytes", got_bytes.size() - b0, 0);
    check("midrst_no_done", n_done - d0, 0);
    check("midrst_no_serr", n_serr - s0, 0);
    check("midrst_no_trunc", n_trunc - t0, 0);
    dbits = {}; push_byte(8'h5A); push_byte(8'h81);
    run_packet(1'b0, 2, 1'b0, "after_rst");

    dbits = {}; push_byte(8'hC3); push_byte(8'h00); push_byte(8'h00);
    run_packet(1'b0, 1, 1'b0, "crc_good");
    check("crc_good_const", last_crc, crc_good);
    dbits = {}; push_byte(8'hC3); push_byte(8'h00); push_byte(8'h01);
    run_packet(1'b0, 1, 1'b0, "crc_bad");
    check("crc_bad_const", last_crc, 1'b0);

    for (int p = 0; p < 40; p++) begin
      int nb, nx;
      bit v;
      dbits = {};
      nb = $urandom_range(1, 4);
      v  = ($urandom_range(0, 5) == 0);
      nx = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0;
      for (int k = 0; k < nb; k++)
        push_byte(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
      for (int k = 0; k < nx; k++) dbits.push_back(1'($urandom));
      run_packet(v, 2, 1'($urandom), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
